// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants, symbol encodings and the zigzag scan order.
// The zigzag table is generated by walking the anti-diagonals rather than stored literally.
package jpeg_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int ZRL_RUN    = 16;

    // Run values that mark the special symbols when paired with a zero coefficient
    localparam logic [3:0] EOB_R = 4'd0;
    localparam logic [3:0] ZRL_R = 4'd15;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_STREAM
    } drain_state_t;

    function automatic logic [5:0] zz_to_raster(input logic [5:0] zz);
        logic [2:0] row;
        logic [2:0] col;
        logic [5:0] raster;
        row    = 3'd0;
        col    = 3'd0;
        raster = 6'd0;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            if (6'(k) == zz) raster = {row, col};
            // even anti-diagonals run up-right, odd ones run down-left
            if (row[0] == col[0]) begin
                if (col == 3'd7) row = row + 3'd1;
                else if (row == 3'd0) col = col + 3'd1;
                else begin
                    row = row - 3'd1;
                    col = col + 3'd1;
                end
            end else begin
                if (row == 3'd7) col = col + 3'd1;
                else if (col == 3'd0) row = row + 3'd1;
                else begin
                    row = row + 3'd1;
                    col = col - 3'd1;
                end
            end
        end
        return raster;
    endfunction

endpackage

// File: rtl/zigzag_lut.sv
// Maps a zigzag scan position to its raster (row*8+col) position.
// Latency: combinational.
// Backpressure: none, pure lookup.
module zigzag_lut
    import jpeg_pkg::*;
(
    input  logic [5:0] zz,
    output logic [5:0] raster
);

    assign raster = zz_to_raster(zz);

endmodule

// File: rtl/coefficient_block_buffer.sv
// Expands run/level symbols into double-buffered 8x8 blocks and streams them in raster order.
// Latency: block close on cycle N -> first out_valid on cycle N+2 when the drain side is idle.
// Backpressure: output obeys out_ready; input has none, symbols arriving with no free bank are dropped.
module coefficient_block_buffer
    import jpeg_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              r_value,
    input  logic signed [IN_W-1:0]  coefficient,
    input  logic                    is_new_coefficient,
    input  logic                    dc_clear,
    output logic signed [OUT_W-1:0] out_sample,
    output logic [5:0]              out_index,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow_err,
    output logic                    index_err
);

    logic signed [OUT_W-1:0] bank_dat [2][BLOCK_SIZE];
    logic [BLOCK_SIZE-1:0]   bank_msk [2];
    logic [1:0]              bank_full;
    logic                    fill_bank;
    logic                    drain_bank;
    logic [5:0]              zz;
    logic signed [OUT_W-1:0] pred;
    drain_state_t            state;
    logic [5:0]              count;

    logic                    stalled;
    logic                    sym_acc;
    logic                    coef_zero;
    logic [6:0]              run_end;
    logic [6:0]              zrl_end;
    logic signed [OUT_W-1:0] coef_ext;
    logic signed [OUT_W-1:0] pred_next;
    logic                    wr_en;
    logic [5:0]              wr_zz;
    logic [5:0]              wr_addr;
    logic signed [OUT_W-1:0] wr_dat;
    logic                    close_blk;
    logic                    set_idx_err;
    logic [5:0]              zz_next;
    logic                    release_bank;
    logic [5:0]              next_idx;
    logic signed [OUT_W-1:0] rd_next;
    logic signed [OUT_W-1:0] rd_first;
    logic signed [OUT_W-1:0] rd_other;

    assign coef_ext = {{(OUT_W-IN_W){coefficient[IN_W-1]}}, coefficient};

    always_comb begin
        stalled     = bank_full[fill_bank];
        sym_acc     = is_new_coefficient && !stalled;
        coef_zero   = (coefficient == '0);
        run_end     = {1'b0, zz} + {3'b000, r_value};
        zrl_end     = {1'b0, zz} + 7'(ZRL_RUN);
        pred_next   = (dc_clear ? '0 : pred) + coef_ext;
        wr_en       = 1'b0;
        wr_zz       = run_end[5:0];
        wr_dat      = coef_ext;
        close_blk   = 1'b0;
        set_idx_err = 1'b0;
        zz_next     = zz;
        if (sym_acc) begin
            if (zz == 6'd0) begin
                wr_en   = 1'b1;
                wr_zz   = 6'd0;
                wr_dat  = pred_next;
                zz_next = 6'd1;
            end else if (coef_zero && r_value == EOB_R) begin
                close_blk = 1'b1;
            end else if (coef_zero && r_value == ZRL_R) begin
                if (zrl_end > 7'd63) begin
                    set_idx_err = 1'b1;
                    close_blk   = 1'b1;
                end else begin
                    zz_next = zrl_end[5:0];
                end
            end else if (run_end > 7'd63) begin
                set_idx_err = 1'b1;
                close_blk   = 1'b1;
            end else begin
                wr_en     = 1'b1;
                zz_next   = run_end[5:0] + 6'd1;
                close_blk = (run_end == 7'd63);
            end
        end
        if (close_blk) zz_next = 6'd0;
    end

    zigzag_lut u_zigzag_lut (
        .zz     (wr_zz),
        .raster (wr_addr)
    );

    // out_valid is always high in STREAM, so ready alone completes a transfer
    assign release_bank = (state == DRAIN_STREAM) && out_ready && (count == 6'd63);
    assign next_idx     = count + 6'd1;

    always_comb begin
        rd_next  = bank_msk[drain_bank][next_idx] ? bank_dat[drain_bank][next_idx] : '0;
        rd_first = bank_msk[drain_bank][0]       ? bank_dat[drain_bank][0]       : '0;
        rd_other = bank_msk[~drain_bank][0]      ? bank_dat[~drain_bank][0]      : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_bank    <= 1'b0;
            zz           <= 6'd0;
            pred         <= '0;
            overflow_err <= 1'b0;
            index_err    <= 1'b0;
            bank_full    <= 2'b00;
            bank_msk[0]  <= '0;
            bank_msk[1]  <= '0;
        end else begin
            zz <= zz_next;
            if (close_blk) fill_bank <= ~fill_bank;
            if (sym_acc && zz == 6'd0) pred <= pred_next;
            else if (dc_clear)         pred <= '0;
            if (is_new_coefficient && stalled) overflow_err <= 1'b1;
            if (set_idx_err)                   index_err    <= 1'b1;
            // a bank is either being filled or drained, never both, so these never collide
            for (int b = 0; b < 2; b++) begin
                if (close_blk && fill_bank == 1'(b))            bank_full[b] <= 1'b1;
                else if (release_bank && drain_bank == 1'(b))   bank_full[b] <= 1'b0;
                if (release_bank && drain_bank == 1'(b))        bank_msk[b] <= '0;
                else if (wr_en && fill_bank == 1'(b))           bank_msk[b][wr_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) bank_dat[fill_bank][wr_addr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= DRAIN_IDLE;
            drain_bank <= 1'b0;
            count      <= 6'd0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_index  <= 6'd0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (bank_full[drain_bank]) begin
                        state      <= DRAIN_STREAM;
                        count      <= 6'd0;
                        out_valid  <= 1'b1;
                        out_sample <= rd_first;
                        out_index  <= 6'd0;
                        out_last   <= 1'b0;
                    end
                end
                DRAIN_STREAM: begin
                    if (out_ready) begin
                        if (count == 6'd63) begin
                            drain_bank <= ~drain_bank;
                            out_index  <= 6'd0;
                            out_last   <= 1'b0;
                            count      <= 6'd0;
                            // chain straight into the other bank to keep 64 cycles per block
                            if (bank_full[~drain_bank]) begin
                                out_sample <= rd_other;
                            end else begin
                                state      <= DRAIN_IDLE;
                                out_valid  <= 1'b0;
                                out_sample <= '0;
                            end
                        end else begin
                            count      <= next_idx;
                            out_sample <= rd_next;
                            out_index  <= next_idx;
                            out_last   <= (next_idx == 6'd63);
                        end
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: doc/coefficient_block_buffer.md
Name: coefficient_block_buffer

Overview:
- Consumes the (r_value, coefficient, is_new_coefficient) symbol stream from Number_Generator and expands zero runs.
- Reconstructs each DC value from its difference and de-zigzags every coefficient into natural 8x8 raster order.
- Double-buffers complete blocks and streams them, 64 samples per block, to the dequantiser/IDCT stage over a valid/ready handshake.
- The input side has no backpressure. It accepts one symbol every cycle.

Parameters:
- IN_W, 8, signed width of incoming coefficient
- OUT_W, 11, signed width of output sample and DC predictor

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- r_value  in  4  run length of zeros preceding coefficient
- coefficient  in  IN_W  signed coefficient; the DC difference for the first symbol of a block
- is_new_coefficient  in  1  symbol valid strobe
- dc_clear  in  1  synchronous pulse that zeroes the DC predictor (restart marker / new scan)
- out_sample  out  OUT_W  signed sample, natural order
- out_index  out  6  raster index (row*8+col) of out_sample
- out_last  out  1  high on index 63
- out_valid  out  1  sample valid
- out_ready  in  1  downstream accept
- overflow_err  out  1  sticky: symbol arrived with no free bank
- index_err  out  1  sticky: run overran index 63

Behaviour:
- Reset (rst low, async): fill bank=0, drain bank=0, both banks empty, write index=0, DC predictor=0. Outputs: out_valid=0, out_sample=0, out_index=0, out_last=0, both error flags=0.
- Storage: two banks, each 64 x OUT_W, plus a 64-bit written-mask per bank. A slot whose mask bit is 0 reads as 0. Clearing a bank means clearing its mask in one cycle, so zero runs never cost write cycles.
- Fill side, one symbol per is_new_coefficient cycle, with zz = write index:
  - zz==0 (DC): pred_next = pred + sign_extend(coefficient), wrapped to OUT_W bits. Write pred_next at raster(0), set pred=pred_next, zz=1. The DC symbol's r_value is ignored.
  - zz>0, r=0 and coefficient=0 (EOB): close block.
  - zz>0, r=15 and coefficient=0 (ZRL): zz += 16. If the result is >63, set index_err and close block. No write.
  - Otherwise: t = zz + r. If t>63, set index_err and close block with no write. Else write sign_extend(coefficient) at raster(zigzag(t)) and set zz = t+1. If t==63, close block.
- Close block: mark fill bank full, toggle fill bank, zz=0.
  - If the other bank is still full, the fill side is stalled.
  - Any symbol arriving while stalled is dropped and sets overflow_err.
- Drain side, FSM IDLE -> STREAM -> IDLE:
  - IDLE: when the drain bank is full, enter STREAM with count=0.
  - STREAM: present bank[count] with out_valid=1. On out_valid & out_ready, count++.
  - When count==63 is accepted: clear that bank's mask, mark it empty, toggle drain bank, return to IDLE.
  - out_valid may not drop while in STREAM. Outputs are registered and hold stable while out_ready=0.
- Latency: a close on cycle N gives out_valid on cycle N+2 if the drain side is idle.
- Throughput: 64 cycles per block with out_ready held high.
- Simultaneous events:
  - Drain releasing bank B and fill closing bank A in the same cycle are legal and independent.
  - A bank released on cycle N is writable on cycle N+1.
  - dc_clear together with a DC symbol: clear first, then add (result = sign_extend(coefficient)).
- Error flags are sticky until reset. Blocks already full still drain normally after an error.

Decomposition:
- Shared package jpeg_pkg: BLOCK_SIZE=64, EOB and ZRL symbol encodings, ZRL_RUN=16, and the zigzag-to-raster table as a constant function.
- One sub-module, zigzag_lut: combinational 6-bit zigzag index -> 6-bit raster index, also reusable by the encoder test model.
- Banks: plain register arrays; no RAM macro required.

Test Plan:
- DC=+5 then EOB, out_ready=1 -> 64 samples; index 0 = 5, others 0, out_last on 63. A second block with DC=-3 then EOB -> index 0 = 2.
- One block: DC=0, (r=0,c=7), (r=2,c=-1), EOB -> raster 1 = 7, raster zigzag(4)=9 = -1, all else 0.
- ZRL x3 then (r=14,c=4) -> write at zigzag 63 = raster 63, block closes without EOB, no index_err.
- ZRL x4 -> index_err=1, block closed, drained as all zeros except DC.
- out_ready=0 while three blocks arrive back to back -> first two blocks held, third symbol sets overflow_err. Releasing out_ready drains blocks 1 and 2 intact.
- rst asserted mid-STREAM at count 20 -> out_valid=0 immediately; after release, the next block's DC uses predictor 0.
